// File: rtl/branch_resolve_if.sv
// Prediction push, resolve and resolution-packet signals shared by fetch/execute and branch_resolve.
interface branch_resolve_if #(parameter int DEPTH = 4);
  logic                     i_pred_valid;
  logic [31:0]              i_pred_pc;
  logic                     i_pred_taken;
  logic [31:0]              i_pred_target;
  logic [7:0]               i_pred_pos;
  logic                     o_pred_ready;
  logic                     i_res_valid;
  logic                     i_res_taken;
  logic [31:0]              i_res_target;
  logic                     o_fire;
  logic [41:0]              o_data;
  logic [$clog2(DEPTH):0]   o_count;
  logic                     o_underflow;

  modport master (
    output i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target, i_pred_pos,
    output i_res_valid, i_res_taken, i_res_target,
    input  o_pred_ready, o_fire, o_data, o_count, o_underflow
  );

  modport slave (
    input  i_pred_valid, i_pred_pc, i_pred_taken, i_pred_target, i_pred_pos,
    input  i_res_valid, i_res_taken, i_res_target,
    output o_pred_ready, o_fire, o_data, o_count, o_underflow
  );
endinterface

// File: rtl/branch_resolve.sv
// In-order prediction FIFO; pops the oldest prediction on resolve, emits a resolution packet
// with a one-cycle strobe, and flushes all younger (wrong-path) entries on mispredict.
module branch_resolve #(
  parameter int DEPTH = 4
) (
  input  logic             fire,
  input  logic             rst,
  branch_resolve_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PONE  = PW'(1);

  logic [31:0]   pc_mem  [DEPTH];
  logic          tkn_mem [DEPTH];
  logic [31:0]   tgt_mem [DEPTH];
  logic [7:0]    pos_mem [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          fire_q, underflow_q;
  logic [41:0]   data_q;

  logic          res_act, mispredict, flush_now, push;
  logic [31:0]   correct_pc;

  assign bus.o_pred_ready = (count < FULL);
  assign bus.o_count      = count;
  assign bus.o_fire       = fire_q;
  assign bus.o_data       = data_q;
  assign bus.o_underflow  = underflow_q;

  always_comb begin
    res_act    = bus.i_res_valid && (count != '0);
    mispredict = (tkn_mem[rd_ptr] != bus.i_res_taken) ||
                 (bus.i_res_taken && (tgt_mem[rd_ptr] != bus.i_res_target));
    flush_now  = res_act && mispredict;
    push       = bus.i_pred_valid && bus.o_pred_ready && !flush_now;
    correct_pc = bus.i_res_taken ? bus.i_res_target : (pc_mem[rd_ptr] + 32'd4);
  end

  // Storage has no reset: contents are only observed through valid pointers.
  always_ff @(posedge fire) begin
    if (push) begin
      pc_mem[wr_ptr]  <= bus.i_pred_pc;
      tkn_mem[wr_ptr] <= bus.i_pred_taken;
      tgt_mem[wr_ptr] <= bus.i_pred_target;
      pos_mem[wr_ptr] <= bus.i_pred_pos;
    end
  end

  always_ff @(posedge fire or posedge rst) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      fire_q      <= 1'b0;
      data_q      <= '0;
      underflow_q <= 1'b0;
    end else begin
      fire_q <= res_act;
      if (res_act)
        data_q <= {1'b1, mispredict, correct_pc, pos_mem[rd_ptr]};
      if (bus.i_res_valid && (count == '0))
        underflow_q <= 1'b1;

      if (flush_now) begin
        count  <= '0;
        rd_ptr <= wr_ptr;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PONE;
        if (res_act)
          rd_ptr <= rd_ptr + PONE;
        case ({push, res_act})
          2'b10:   count <= count + CONE;
          2'b01:   count <= count - CONE;
          default: count <= count;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, hand sequences and random traffic vs a queue model.
module tb_branch_resolve;
  localparam int DEPTH = 4;

  logic fire = 1'b0;
  logic rst  = 1'b1;
  always #5 fire = ~fire;

  branch_resolve_if #(.DEPTH(DEPTH)) bus ();
  branch_resolve #(.DEPTH(DEPTH)) dut (.fire(fire), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic [7:0]  pos;
  } ent_t;

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        pt;
    logic [31:0] ptgt;
    logic [7:0]  pos;
    logic        rv;
    logic        rt;
    logic [31:0] rtgt;
    logic        e_fire;
    logic [41:0] e_data;
    int          e_count;
  } vec_t;

  int checks = 0;
  int errors = 0;

  ent_t        q[$];
  logic        m_fire;
  logic [41:0] m_data;
  logic        m_under;

  task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_fire  = 1'b0;
    m_data  = '0;
    m_under = 1'b0;
  endtask

  // Reference: pop head, compare against outcome, flush on mispredict, then accept push if allowed.
  task automatic model_edge();
    int   pre_n;
    logic mis;
    ent_t h;
    ent_t e;
    pre_n = q.size();
    mis   = 1'b0;
    m_fire = 1'b0;
    if (bus.i_res_valid && pre_n == 0) m_under = 1'b1;
    if (bus.i_res_valid && pre_n != 0) begin
      h   = q.pop_front();
      mis = (h.taken != bus.i_res_taken) || (bus.i_res_taken && h.target != bus.i_res_target);
      m_fire = 1'b1;
      m_data = {1'b1, mis, (bus.i_res_taken ? bus.i_res_target : h.pc + 32'd4), h.pos};
      if (mis) q.delete();
    end
    if (bus.i_pred_valid && pre_n < DEPTH && !mis) begin
      e.pc = bus.i_pred_pc; e.taken = bus.i_pred_taken;
      e.target = bus.i_pred_target; e.pos = bus.i_pred_pos;
      q.push_back(e);
    end
  endtask

  task automatic check_model();
    chk("fire",      42'(bus.o_fire),       42'(m_fire));
    chk("data",      bus.o_data,            m_data);
    chk("count",     42'(bus.o_count),      42'(q.size()));
    chk("ready",     42'(bus.o_pred_ready), 42'(q.size() < DEPTH));
    chk("underflow", 42'(bus.o_underflow),  42'(m_under));
  endtask

  task automatic step();
    model_edge();
    @(posedge fire);
    #1;
    check_model();
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                       input logic [7:0] pos, input logic rv, input logic rt, input logic [31:0] rtgt);
    bus.i_pred_valid = pv; bus.i_pred_pc = pc; bus.i_pred_taken = pt;
    bus.i_pred_target = ptgt; bus.i_pred_pos = pos;
    bus.i_res_valid = rv; bus.i_res_taken = rt; bus.i_res_target = rtgt;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge fire);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_model();
  endtask

  vec_t tbl[14];

  initial begin
    ent_t h;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    tbl[0]  = '{1, 32'h1000, 1, 32'h2000, 8'd3,  0, 0, 0,          0, 42'h0, 1};
    tbl[1]  = '{0, 0, 0, 0, 0,                   1, 1, 32'h2000,   1, {2'b10, 32'h00002000, 8'h03}, 0};
    tbl[2]  = '{0, 0, 0, 0, 0,                   0, 0, 0,          0, {2'b10, 32'h00002000, 8'h03}, 0};
    tbl[3]  = '{1, 32'h1000, 0, 32'h0, 8'd5,     0, 0, 0,          0, {2'b10, 32'h00002000, 8'h03}, 1};
    tbl[4]  = '{0, 0, 0, 0, 0,                   1, 1, 32'h3000,   1, {2'b11, 32'h00003000, 8'h05}, 0};
    tbl[5]  = '{1, 32'hFFFFFFFC, 0, 32'h0, 8'd9, 0, 0, 0,          0, {2'b11, 32'h00003000, 8'h05}, 1};
    tbl[6]  = '{0, 0, 0, 0, 0,                   1, 0, 32'h0,      1, {2'b10, 32'h00000000, 8'h09}, 0};
    tbl[7]  = '{1, 32'h4000, 0, 32'h0, 8'd10,    0, 0, 0,          0, {2'b10, 32'h00000000, 8'h09}, 1};
    tbl[8]  = '{1, 32'h4004, 0, 32'h0, 8'd11,    0, 0, 0,          0, {2'b10, 32'h00000000, 8'h09}, 2};
    tbl[9]  = '{1, 32'h4008, 0, 32'h0, 8'd12,    0, 0, 0,          0, {2'b10, 32'h00000000, 8'h09}, 3};
    tbl[10] = '{1, 32'h400C, 0, 32'h0, 8'd13,    0, 0, 0,          0, {2'b10, 32'h00000000, 8'h09}, 4};
    tbl[11] = '{1, 32'h4010, 0, 32'h0, 8'd14,    0, 0, 0,          0, {2'b10, 32'h00000000, 8'h09}, 4};
    tbl[12] = '{1, 32'h5000, 0, 32'h0, 8'd15,    1, 1, 32'h9999,   1, {2'b11, 32'h00009999, 8'd10}, 0};
    tbl[13] = '{0, 0, 0, 0, 0,                   1, 0, 32'h0,      0, {2'b11, 32'h00009999, 8'd10}, 0};

    #12;
    chk("rst_fire",  42'(bus.o_fire), 42'(0));
    chk("rst_data",  bus.o_data, 42'(0));
    chk("rst_count", 42'(bus.o_count), 42'(0));
    chk("rst_ready", 42'(bus.o_pred_ready), 42'(1));
    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].pv, tbl[i].pc, tbl[i].pt, tbl[i].ptgt, tbl[i].pos, tbl[i].rv, tbl[i].rt, tbl[i].rtgt);
      step();
      chk($sformatf("tbl%0d_fire", i),  42'(bus.o_fire),  42'(tbl[i].e_fire));
      chk($sformatf("tbl%0d_data", i),  bus.o_data,        tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), 42'(bus.o_count), 42'(tbl[i].e_count));
      if (i == 10) chk("full_ready", 42'(bus.o_pred_ready), 42'(0));
    end
    chk("underflow_set", 42'(bus.o_underflow), 42'(1));

    // Steady state: one entry in flight, push + correct resolve each cycle across pointer wrap.
    drive(1, 32'h8000, 1, 32'h8100, 8'd40, 0, 0, 0);
    step();
    for (int i = 0; i < 10; i++) begin
      h = q[0];
      drive(1, 32'h8000 + 32'(i) * 32'h10, i[0], 32'h9000 + 32'(i), 8'(41 + i), 1, h.taken, h.target);
      step();
      chk("steady_count", 42'(bus.o_count), 42'(1));
      chk("steady_fire",  42'(bus.o_fire),  42'(1));
      chk("steady_order", 42'(bus.o_data[7:0]), 42'(40 + i));
    end

    // Reset lands while o_fire is high.
    h = q[0];
    drive(0, 0, 0, 0, 0, 1, h.taken, h.target);
    step();
    chk("pre_rst_fire", 42'(bus.o_fire), 42'(1));
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_fire",  42'(bus.o_fire),       42'(0));
    chk("async_data",  bus.o_data,            42'(0));
    chk("async_count", 42'(bus.o_count),      42'(0));
    chk("async_ready", 42'(bus.o_pred_ready), 42'(1));
    @(posedge fire);
    #2;
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
            32'h100 * 32'($urandom_range(1, 2)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)), 32'h100 * 32'($urandom_range(1, 2)));
      if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
        bus.i_res_taken  = q[0].taken;
        bus.i_res_target = q[0].target;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
